shift_reg_day6: RTL and testbench

- Registered one-bit logical shifter: on each enabled clock edge it captures a parallel input word. It presents two versions of that word, one shifted left by one bit and one shifted right by one bit.
- Small datapath leaf block with no handshake. It is used wherever a registered ×2 or ÷2 (unsigned) of a parallel word is needed.

---
 rtl/shift_reg_day6_pkg.sv | 8 +
 rtl/shift_reg_day6.sv | 38 +++
 tb/tb_shift_reg_day6.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/shift_reg_day6_pkg.sv
// shift_reg_day6_pkg
//   Shared constants for the registered one-bit shifter.
//   SHIFT_REG_DEFAULT_WIDTH : default data width used by shift_reg_day6.
package shift_reg_day6_pkg;

  localparam int SHIFT_REG_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/shift_reg_day6.sv
// shift_reg_day6
//   Registered one-bit logical shifter. On each enabled clock edge the
//   parallel word x_i is captured twice: once shifted left by one (x2) and
//   once shifted right by one (unsigned /2). Both outputs update together.
//
//   Ports
//     clk        : rising-edge clock
//     reset      : asynchronous active-low reset (0 = outputs forced to 0)
//     shft       : 1 = capture shifted x_i on this edge, 0 = hold
//     x_i        : parallel data word
//     shft_left  : registered {x_i[WIDTH-2:0], 1'b0}
//     shft_right : registered {1'b0, x_i[WIDTH-1:1]}
module shift_reg_day6
  import shift_reg_day6_pkg::*;
#(
  parameter int WIDTH = SHIFT_REG_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shft,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] shft_left,
  output logic [WIDTH-1:0] shft_right
);

  // Each capture works on the current x_i, never on the register contents,
  // so repeated enables with a steady input do not accumulate shifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shft_left  <= '0;
      shft_right <= '0;
    end else if (shft) begin
      shft_left  <= {x_i[WIDTH-2:0], 1'b0};
      shft_right <= {1'b0, x_i[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_shift_reg_day6.sv
// tb_shift_reg_day6
//   Scoreboard bench for shift_reg_day6: the driver pushes the expected
//   outputs for every clock edge into a queue, a monitor pops and compares
//   one entry shortly after each rising edge.
module tb_shift_reg_day6;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         shft = 1'b0;
  logic [W-1:0] x_i = '0;
  logic [W-1:0] shft_left;
  logic [W-1:0] shft_right;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Reference state: what the outputs should currently hold.
  int model_l = 0;
  int model_r = 0;

  shift_reg_day6 #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .shft       (shft),
    .x_i        (x_i),
    .shft_left  (shft_left),
    .shft_right (shft_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // One clock cycle of stimulus; the model is updated at the edge using
  // plain arithmetic: x2 modulo 2^W and integer /2.
  task automatic step(input logic r, input logic s, input logic [W-1:0] x);
    exp_t e;
    @(negedge clk);
    reset = r;
    shft  = s;
    x_i   = x;
    @(posedge clk);
    if (!r) begin
      model_l = 0;
      model_r = 0;
    end else if (s) begin
      model_l = (int'(x) * 2) % (1 << W);
      model_r = int'(x) / 2;
    end
    e.l = W'(model_l);
    e.r = W'(model_r);
    exp_q.push_back(e);
  endtask

  // Drop reset between edges and verify outputs clear with no clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_left", shft_left, '0);
    check("async_rst_right", shft_right, '0);
    model_l = 0;
    model_r = 0;
  endtask

  // Monitor: outputs are presented every cycle; compare one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("left", shft_left, e.l);
        check("right", shft_right, e.r);
      end
    end
  end

  initial begin
    logic r_rand;
    logic s_rand;

    // Reset held with shft active.
    repeat (3) step(1'b0, 1'b1, 4'b1010);

    // Basic shift.
    step(1'b1, 1'b1, 4'b0110);

    // Capture then hold with a changed input.
    step(1'b1, 1'b1, 4'b1010);
    repeat (3) step(1'b1, 1'b0, 4'b0010);

    // Edge bits.
    step(1'b1, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 4'b1000);
    step(1'b1, 1'b1, 4'b0001);

    // No accumulation with a steady input.
    repeat (4) step(1'b1, 1'b1, 4'b1100);

    // Reset mid-operation, then release with shft low.
    step(1'b1, 1'b1, 4'b1111);
    async_reset_check();
    repeat (2) step(1'b1, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 4'b1011);

    // Randomized traffic with occasional reset and hold cycles.
    for (int i = 0; i < 300; i++) begin
      r_rand = ($urandom_range(0, 15) != 0);
      s_rand = ($urandom_range(0, 3) != 0);
      step(r_rand, s_rand, W'($urandom));
      if ($urandom_range(0, 40) == 0) async_reset_check();
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
